cpu_host: RTL and testbench
===========================

# cpu_host

Host-side controller for the A-RISC core. It accepts a byte-command stream (valid/ready) that loads instruction and data RAM, starts the core and waits for it to finish. It then streams data-RAM contents back out. It sits between an external link (UART/JTAG bridge) and the core's `start`/`idle` handshake and RAM write ports, and owns both RAMs whenever the core is idle.

## Interface
- `W`, 8: data/address width; link bytes are 8 bits, so only W=8 is supported
- `TIMEOUT_CYCLES`, 65535: run watchdog limit; used only with `CPU_HOST_TIMEOUT_EN`
- `clk` in 1: single clock
- `rstn` in 1: reset, asynchronous, active-low
- `s_valid` in 1, `s_ready` out 1, `s_data` in 8: command byte stream in
- `m_valid` out 1, `m_ready` in 1, `m_data` out 8: response byte stream out
- `iram_we` out 1, `iram_addr` out W, `iram_din` out 16: IRAM write port
- `dram_we` out 1, `dram_addr` out W, `dram_din` out W: DRAM write/read address
- `dram_dout` in W: DRAM read data, 1-cycle latency
- `cpu_start` out 1: start pulse to core
- `cpu_idle` in 1: core idle flag
- `host_mem_sel` out 1: 1 means the top-level RAM muxes select host ports; 0 means they select core ports

## Operation
- Commands (first byte), then operands:
  - 0x01 LOAD_I addr cnt, then 2·N bytes (low byte first)
  - 0x02 LOAD_D addr cnt, then N bytes
  - 0x03 RUN
  - 0x04 DUMP addr cnt
- cnt=0 means N=256.
- States: S_CMD, S_ADDR, S_CNT, S_ILO, S_IHI, S_DDAT, S_RUN_START, S_RUN_GAP, S_RUN_WAIT, S_RD_REQ, S_RD_CAP, S_TX.
- Loads:
  - Each completed word/byte produces one write at the current address.
  - The address then increments with mod-256 wrap (addr=0xFF, N=2 writes 0xFF then 0x00).
  - After N writes, emit ack 0xA5 and return to S_CMD.
- RUN:
  - If `cpu_idle`=0 in S_RUN_START, emit 0xE2 and return to S_CMD. No start.
  - Otherwise `cpu_start`=1 for exactly one cycle, then S_RUN_GAP for one cycle (the core drops idle the cycle after start), then S_RUN_WAIT.
  - On `cpu_idle`=1, emit 0xA5.
- DUMP: for each of N addresses:
  - S_RD_REQ drives `dram_addr`.
  - S_RD_CAP captures `dram_dout` into `m_data`.
  - S_TX holds `m_valid` until `m_ready`.
- Unknown command byte: emit 0xE1, stay in S_CMD.
- `host_mem_sel`=0 in S_RUN_START/GAP/WAIT, 1 otherwise.
- Reset mid-operation:
  - Abort to S_CMD.
  - RAM contents already written remain.
  - A partial LOAD_I word is discarded.

## Timing
- Reset values:
  - `s_ready`=0, `m_valid`=0, `m_data`=0, `iram_we`=0, `dram_we`=0
  - `iram_addr`=0, `iram_din`=0, `dram_addr`=0, `dram_din`=0
  - `cpu_start`=0, `host_mem_sel`=1
  - state S_CMD
- `s_ready`=1 in S_CMD, S_ADDR, S_CNT, S_ILO, S_IHI, S_DDAT and when no response is pending; 0 elsewhere.
- A byte transfers on the cycle with `s_valid`&&`s_ready`.
- Write outputs are registered. `iram_we`/`dram_we` are one-cycle pulses in the cycle after the final byte of a word/byte handshake, with addr/din stable that cycle.
- Back-to-back bytes sustain one RAM write per byte (DRAM) or per two bytes (IRAM).
- `m_valid`, once high, holds `m_data` constant until `m_ready`. No new command byte is accepted while a response is pending.
- RUN latency: `cpu_start` is asserted 1 cycle after the RUN byte; the ack is visible 1 cycle after `cpu_idle` is sampled high in S_RUN_WAIT.
- DUMP: first `m_valid` 2 cycles after the cnt byte; at most one byte per 3 cycles.

## Configuration
- `CPU_HOST_TIMEOUT_EN` defined:
  - A cycle counter runs in S_RUN_WAIT.
  - Reaching `TIMEOUT_CYCLES` without `cpu_idle` emits 0xEE, sets `host_mem_sel`=1 and returns to S_CMD.
  - The core is not reset.
- Undefined: no counter logic; S_RUN_WAIT waits indefinitely.

## Structure
- `cpu_host_pkg`:
  - command codes (CMD_LOAD_I=1, CMD_LOAD_D=2, CMD_RUN=3, CMD_DUMP=4)
  - response bytes (RSP_ACK=8'hA5, RSP_BADCMD=8'hE1, RSP_BUSY=8'hE2, RSP_TIMEOUT=8'hEE)
  - state enum type
- One sub-module, `cpu_host_tx`: the response output register with valid/ready hold and a pending flag used to gate `s_ready`.

## Test plan
- 01 10 02 34 12 78 56 → `iram_we` at addr 0x10 din 0x1234, then 0x11 din 0x5678; one 0xA5 out.
- 02 FF 02 AA BB → `dram_we` at 0xFF din 0xAA, then 0x00 din 0xBB (wrap); 0xA5.
- 03 with model core that goes busy for 20 cycles → single-cycle `cpu_start`, `host_mem_sel`=0 for the run, 0xA5 after idle; 03 while `cpu_idle`=0 → 0xE2, no start.
- 04 20 03 with DRAM[0x20..0x22]=01,02,03 and `m_ready` toggling 1/0 → output 01 02 03, each held stable until accepted.
- Byte 0x09 → 0xE1 and the next valid command works; `rstn` pulsed mid LOAD_I after low byte → outputs at reset values, no IRAM write.
- With `CPU_HOST_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, core never idle → 0xEE at cycle 100 of S_RUN_WAIT.

Source files
------------

// File: rtl/cpu_host_pkg.sv
// Shared definitions for the A-RISC host controller: command codes, response bytes,
// FSM state type and a state-classification helper.
package cpu_host_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IWORD_W = 16;
  localparam int unsigned CNT_W   = 9;

  localparam logic [BYTE_W-1:0] CMD_LOAD_I = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_LOAD_D = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_RUN    = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_DUMP   = 8'h04;

  localparam logic [BYTE_W-1:0] RSP_ACK     = 8'hA5;
  localparam logic [BYTE_W-1:0] RSP_BADCMD  = 8'hE1;
  localparam logic [BYTE_W-1:0] RSP_BUSY    = 8'hE2;
  localparam logic [BYTE_W-1:0] RSP_TIMEOUT = 8'hEE;

  typedef enum logic [3:0] {
    S_CMD, S_ADDR, S_CNT, S_ILO, S_IHI, S_DDAT,
    S_RUN_START, S_RUN_GAP, S_RUN_WAIT, S_RD_REQ, S_RD_CAP, S_TX
  } state_e;

  // States in which the command stream may hand us a byte.
  function automatic logic is_input_state(input state_e s);
    return s inside {S_CMD, S_ADDR, S_CNT, S_ILO, S_IHI, S_DDAT};
  endfunction

  // The core owns the RAMs only while a run is in flight.
  function automatic logic is_run_state(input state_e s);
    return s inside {S_RUN_START, S_RUN_GAP, S_RUN_WAIT};
  endfunction

endpackage

// File: rtl/cpu_host_tx.sv
// Response byte register: holds m_data/m_valid until accepted and reports the
// next-cycle pending state so the command path can throttle s_ready.
module cpu_host_tx
  import cpu_host_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [BYTE_W-1:0] m_data,
  output logic              pending_nxt_c
);

  logic              m_valid_q, m_valid_d;
  logic [BYTE_W-1:0] m_data_q, m_data_d;

  always_comb begin
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_data        = m_data_q;
  assign pending_nxt_c = m_valid_d;

endmodule

// File: rtl/cpu_host.sv
// Host controller: byte-command loader for IRAM/DRAM, core run handshake and DRAM dump.
// Optional run watchdog enabled by defining CPU_HOST_TIMEOUT_EN.
module cpu_host
  import cpu_host_pkg::*;
#(
  parameter int unsigned W              = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [BYTE_W-1:0]  s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [BYTE_W-1:0]  m_data,
  output logic               iram_we,
  output logic [W-1:0]       iram_addr,
  output logic [IWORD_W-1:0] iram_din,
  output logic               dram_we,
  output logic [W-1:0]       dram_addr,
  output logic [W-1:0]       dram_din,
  input  logic [W-1:0]       dram_dout,
  output logic               cpu_start,
  input  logic               cpu_idle,
  output logic               host_mem_sel
);

  state_e               state_q, state_d;
  logic [BYTE_W-1:0]    cmd_q, cmd_d;
  logic [W-1:0]         addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BYTE_W-1:0]    lo_q, lo_d;
  logic                 s_ready_q, s_ready_d;
  logic                 iram_we_q, iram_we_d;
  logic [W-1:0]         iram_addr_q, iram_addr_d;
  logic [IWORD_W-1:0]   iram_din_q, iram_din_d;
  logic                 dram_we_q, dram_we_d;
  logic [W-1:0]         dram_addr_q, dram_addr_d;
  logic [W-1:0]         dram_din_q, dram_din_d;
  logic                 cpu_start_q, cpu_start_d;
  logic                 host_mem_sel_q, host_mem_sel_d;
  logic                 xfer_c, rsp_load_c, pending_nxt_c;
  logic [BYTE_W-1:0]    rsp_data_c;

`ifdef CPU_HOST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign xfer_c = s_valid && s_ready_q;

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    lo_d           = lo_q;
    iram_we_d      = 1'b0;
    iram_addr_d    = iram_addr_q;
    iram_din_d     = iram_din_q;
    dram_we_d      = 1'b0;
    dram_addr_d    = dram_addr_q;
    dram_din_d     = dram_din_q;
    cpu_start_d    = 1'b0;
    rsp_load_c     = 1'b0;
    rsp_data_c     = RSP_ACK;
`ifdef CPU_HOST_TIMEOUT_EN
    tmo_d          = tmo_q;
`endif
    case (state_q)
      S_CMD: if (xfer_c) begin
        if (s_data inside {CMD_LOAD_I, CMD_LOAD_D, CMD_DUMP}) begin
          cmd_d   = s_data;
          state_d = S_ADDR;
        end else if (s_data == CMD_RUN) begin
          // Start is registered, so it is qualified by idle as seen on the RUN byte.
          cpu_start_d = cpu_idle;
          state_d     = S_RUN_START;
        end else begin
          rsp_load_c = 1'b1;
          rsp_data_c = RSP_BADCMD;
        end
      end
      S_ADDR: if (xfer_c) begin
        addr_d  = W'(s_data);
        state_d = S_CNT;
      end
      S_CNT: if (xfer_c) begin
        cnt_d = (s_data == '0) ? CNT_W'(256) : CNT_W'(s_data);
        if (cmd_q == CMD_LOAD_I)      state_d = S_ILO;
        else if (cmd_q == CMD_LOAD_D) state_d = S_DDAT;
        else begin
          dram_addr_d = addr_q;
          state_d     = S_RD_REQ;
        end
      end
      S_ILO: if (xfer_c) begin
        lo_d    = s_data;
        state_d = S_IHI;
      end
      S_IHI: if (xfer_c) begin
        iram_we_d   = 1'b1;
        iram_addr_d = addr_q;
        iram_din_d  = {s_data, lo_q};
        addr_d      = addr_q + W'(1);
        cnt_d       = cnt_q - CNT_W'(1);
        state_d     = S_ILO;
        if (cnt_q == CNT_W'(1)) begin
          rsp_load_c = 1'b1;
          state_d    = S_CMD;
        end
      end
      S_DDAT: if (xfer_c) begin
        dram_we_d   = 1'b1;
        dram_addr_d = addr_q;
        dram_din_d  = W'(s_data);
        addr_d      = addr_q + W'(1);
        cnt_d       = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_load_c = 1'b1;
          state_d    = S_CMD;
        end
      end
      S_RUN_START: begin
        if (!cpu_idle || !cpu_start_q) begin
          rsp_load_c = 1'b1;
          rsp_data_c = RSP_BUSY;
          state_d    = S_CMD;
        end else begin
          state_d = S_RUN_GAP;
        end
      end
      S_RUN_GAP: begin
`ifdef CPU_HOST_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (cpu_idle) begin
          rsp_load_c = 1'b1;
          state_d    = S_CMD;
        end
`ifdef CPU_HOST_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_load_c = 1'b1;
          rsp_data_c = RSP_TIMEOUT;
          state_d    = S_CMD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rsp_load_c = 1'b1;
        rsp_data_c = BYTE_W'(dram_dout);
        state_d    = S_TX;
      end
      S_TX: if (m_valid && m_ready) begin
        addr_d = addr_q + W'(1);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_CMD;
        end else begin
          dram_addr_d = addr_d;
          state_d     = S_RD_REQ;
        end
      end
      default: state_d = S_CMD;
    endcase
    host_mem_sel_d = !is_run_state(state_d);
    s_ready_d      = is_input_state(state_d) && !pending_nxt_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_CMD;
      cmd_q          <= '0;
      addr_q         <= '0;
      cnt_q          <= '0;
      lo_q           <= '0;
      s_ready_q      <= 1'b0;
      iram_we_q      <= 1'b0;
      iram_addr_q    <= '0;
      iram_din_q     <= '0;
      dram_we_q      <= 1'b0;
      dram_addr_q    <= '0;
      dram_din_q     <= '0;
      cpu_start_q    <= 1'b0;
      host_mem_sel_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      addr_q         <= addr_d;
      cnt_q          <= cnt_d;
      lo_q           <= lo_d;
      s_ready_q      <= s_ready_d;
      iram_we_q      <= iram_we_d;
      iram_addr_q    <= iram_addr_d;
      iram_din_q     <= iram_din_d;
      dram_we_q      <= dram_we_d;
      dram_addr_q    <= dram_addr_d;
      dram_din_q     <= dram_din_d;
      cpu_start_q    <= cpu_start_d;
      host_mem_sel_q <= host_mem_sel_d;
    end
  end

`ifdef CPU_HOST_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`endif

  cpu_host_tx u_tx (
    .clk          (clk),
    .rstn         (rstn),
    .load         (rsp_load_c),
    .load_data    (rsp_data_c),
    .m_ready      (m_ready),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .pending_nxt_c(pending_nxt_c)
  );

  assign s_ready      = s_ready_q;
  assign iram_we      = iram_we_q;
  assign iram_addr    = iram_addr_q;
  assign iram_din     = iram_din_q;
  assign dram_we      = dram_we_q;
  assign dram_addr    = dram_addr_q;
  assign dram_din     = dram_din_q;
  assign cpu_start    = cpu_start_q;
  assign host_mem_sel = host_mem_sel_q;

endmodule

// File: tb/tb_cpu_host.sv
// Directed bench for cpu_host: loads, run handshake, dump with back-pressure,
// bad command and mid-load reset; watchdog case when CPU_HOST_TIMEOUT_EN is defined.
module tb_cpu_host;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        iram_we, dram_we;
  logic [7:0]  iram_addr, dram_addr, dram_din;
  logic [15:0] iram_din;
  logic [7:0]  dram_dout = 8'h00;
  logic        cpu_start, cpu_idle, host_mem_sel;

  int errs = 0;
  int checks = 0;

  logic [7:0]  mem [256];
  logic [23:0] iw_q [$];
  logic [15:0] dw_q [$];
  logic [7:0]  rq [$];
  int          starts = 0;
  int          busy = 0;
  bit          start_pend = 0, tog_en = 0, core_busy_hold = 0, core_never = 0;
  bit          hold_v = 0;
  logic [7:0]  hold_d = 8'h00;

  always #5 clk = ~clk;

  cpu_host #(.W(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .iram_we(iram_we), .iram_addr(iram_addr), .iram_din(iram_din),
    .dram_we(dram_we), .dram_addr(dram_addr), .dram_din(dram_din),
    .dram_dout(dram_dout),
    .cpu_start(cpu_start), .cpu_idle(cpu_idle), .host_mem_sel(host_mem_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Mid-cycle monitor: write capture, DRAM model, response capture and hold rule.
  always @(negedge clk) begin
    if (iram_we) iw_q.push_back({iram_addr, iram_din});
    if (dram_we) begin
      dw_q.push_back({dram_addr, dram_din});
      mem[dram_addr] = dram_din;
    end
    if (m_valid && m_ready) rq.push_back(m_data);
    if (cpu_start) starts++;
    if (hold_v) check("m_hold", {23'b0, m_valid, m_data}, {23'b0, 1'b1, hold_d});
    hold_v = rstn && m_valid && !m_ready;
    hold_d = m_data;
  end

  always @(posedge clk) dram_dout <= mem[dram_addr];

  initial forever begin
    @(posedge clk); #1;
    m_ready = tog_en ? ~m_ready : 1'b1;
  end

  // Core model: drops idle the cycle after start, busy 20 cycles.
  initial forever begin
    @(posedge clk); #1;
    if (core_busy_hold) cpu_idle = 1'b0;
    else if (start_pend) begin
      start_pend = 0;
      cpu_idle = 1'b0;
      busy = core_never ? -1 : 20;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) cpu_idle = 1'b1;
    end
    if (cpu_start) start_pend = 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && n < 300) begin step(); n++; end
    if (!s_ready) check("send_s_ready", {31'b0, s_ready}, 32'd1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [7:0] exp);
    int n = 0;
    while (rq.size() == 0 && n < 500) begin step(); n++; end
    if (rq.size() == 0) check({tag, "_none"}, rq.size(), 32'd1);
    else check(tag, {24'b0, rq.pop_front()}, {24'b0, exp});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
    check({tag, "_m"}, {23'b0, m_valid, m_data}, 32'd0);
    check({tag, "_iram"}, {7'b0, iram_we, iram_addr, iram_din}, 32'd0);
    check({tag, "_dram"}, {15'b0, dram_we, dram_addr, dram_din}, 32'd0);
    check({tag, "_start_sel"}, {30'b0, cpu_start, host_mem_sel}, 32'd1);
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    s_valid = 1'b0; s_data = 8'h00; cpu_idle = 1'b1;
    #12;
    check_reset("rst");
    rstn = 1'b1;
    step(2);
    check("s_ready_idle", {31'b0, s_ready}, 32'd1);

    // LOAD_I two words at 0x10
    send(8'h01); send(8'h10); send(8'h02); send(8'h34); send(8'h12);
    check("li_pulse0", {7'b0, iram_we, iram_addr, iram_din}, {7'b0, 1'b1, 8'h10, 16'h1234});
    send(8'h78); send(8'h56);
    check("li_pulse1", {7'b0, iram_we, iram_addr, iram_din}, {7'b0, 1'b1, 8'h11, 16'h5678});
    step();
    check("li_pulse_end", {31'b0, iram_we}, 32'd0);
    expect_rsp("li_ack", 8'hA5);
    step(3);
    check("li_nwr", iw_q.size(), 32'd2);
    if (iw_q.size() == 2) begin
      check("li_w0", {8'b0, iw_q[0]}, {8'b0, 8'h10, 16'h1234});
      check("li_w1", {8'b0, iw_q[1]}, {8'b0, 8'h11, 16'h5678});
    end
    check("li_nrsp", rq.size(), 32'd0);
    iw_q.delete();

    // LOAD_D with address wrap
    send(8'h02); send(8'hFF); send(8'h02); send(8'hAA); send(8'hBB);
    expect_rsp("ld_ack", 8'hA5);
    step(2);
    check("ld_nwr", dw_q.size(), 32'd2);
    if (dw_q.size() == 2) begin
      check("ld_w0", {16'b0, dw_q[0]}, {16'b0, 16'hFFAA});
      check("ld_w1", {16'b0, dw_q[1]}, {16'b0, 16'h00BB});
    end
    dw_q.delete();

    // RUN with cooperative core
    s0 = starts;
    send(8'h03);
    check("run_start", {30'b0, cpu_start, host_mem_sel}, 32'd2);
    step();
    check("run_gap", {30'b0, cpu_start, host_mem_sel}, 32'd0);
    step(5);
    check("run_wait_sel", {31'b0, host_mem_sel}, 32'd0);
    expect_rsp("run_ack", 8'hA5);
    check("run_idle_at_ack", {31'b0, cpu_idle}, 32'd1);
    check("run_nstart", starts - s0, 32'd1);
    check("run_sel_back", {31'b0, host_mem_sel}, 32'd1);

    // RUN while core busy
    core_busy_hold = 1; cpu_idle = 1'b0;
    s0 = starts;
    send(8'h03);
    expect_rsp("run_busy", 8'hE2);
    check("busy_nstart", starts - s0, 32'd0);
    core_busy_hold = 0; cpu_idle = 1'b1;
    step(2);

    // DUMP 3 bytes from 0x20 with toggling m_ready
    send(8'h02); send(8'h20); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
    expect_rsp("ld2_ack", 8'hA5);
    dw_q.delete();
    step(2);
    tog_en = 1;
    send(8'h04); send(8'h20); send(8'h03);
    check("dump_lat0", {31'b0, m_valid}, 32'd0);
    step();
    check("dump_lat1", {31'b0, m_valid}, 32'd0);
    step();
    check("dump_first", {23'b0, m_valid, m_data}, {23'b0, 1'b1, 8'h01});
    expect_rsp("dump0", 8'h01);
    expect_rsp("dump1", 8'h02);
    expect_rsp("dump2", 8'h03);
    tog_en = 0;
    step(6);
    check("dump_nrsp", rq.size(), 32'd0);

    // Bad command then a working command
    send(8'h09);
    expect_rsp("badcmd", 8'hE1);
    send(8'h02); send(8'h30); send(8'h01); send(8'h5A);
    expect_rsp("after_bad_ack", 8'hA5);
    step(2);
    check("after_bad_nwr", dw_q.size(), 32'd1);
    if (dw_q.size() == 1) check("after_bad_w", {16'b0, dw_q[0]}, {16'b0, 16'h305A});
    dw_q.delete();

    // Reset mid LOAD_I after the low byte
    iw_q.delete();
    send(8'h01); send(8'h40); send(8'h01); send(8'h77);
    rstn = 1'b0;
    #2;
    check_reset("rst_mid");
    step();
    rstn = 1'b1;
    step(3);
    check("rst_no_iwr", iw_q.size(), 32'd0);
    send(8'h02); send(8'h50); send(8'h01); send(8'h11);
    expect_rsp("rst_after_ack", 8'hA5);
    step(2);
    check("rst_after_nwr", dw_q.size(), 32'd1);
    if (dw_q.size() == 1) check("rst_after_w", {16'b0, dw_q[0]}, {16'b0, 16'h5011});
    check("rst_mem_kept", {24'b0, mem[8'h21]}, {24'b0, 8'h02});

`ifdef CPU_HOST_TIMEOUT_EN
    // Core never returns to idle: watchdog fires after 100 wait cycles
    core_never = 1;
    send(8'h03);
    step(101);
    check("tmo_before", {31'b0, m_valid}, 32'd0);
    step();
    check("tmo_rsp", {22'b0, m_valid, host_mem_sel, m_data}, {22'b0, 1'b1, 1'b1, 8'hEE});
    expect_rsp("tmo_pop", 8'hEE);
    core_never = 0;
    busy = 0;
    cpu_idle = 1'b1;
    step(2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
